pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator at the head of the fetch pipeline. Holds the architectural fetch address and advances it by a fixed step when the fetch stage accepts it. Applies trap and jump redirects with fixed priority and tags every address with an epoch bit so fetch can discard stale requests. Replaces the fixed 64-bit PC with a width-, reset-vector- and step-configurable block that drives a valid/ready interface.

## Interface

- AW, 64: address width in bits.
- RESET_VEC, 0: address fetched first after reset, AW bits.
- STEP, 4: increment per accepted address. Legal values are 2, 4 and 8.
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk, asserted when 0.
- trap_en_i  input  1  trap redirect request, highest priority.
- trap_addr_i  input  AW  trap target.
- jump_en_i  input  1  branch/jump redirect request from execute.
- jump_addr_i  input  AW  jump target.
- hold_i  input  1  pipeline hold; blocks advance, does not block redirects.
- pc_o  output  AW  current fetch address.
- pc_valid_o  output  1  pc_o is a valid fetch request.
- pc_ready_i  input  1  fetch accepts pc_o this cycle.
- epoch_o  output  1  epoch tag of pc_o; toggles on every taken redirect.
- redirect_o  output  1  one-cycle pulse: a redirect was taken on the previous edge.
- misalign_o  output  1  one-cycle pulse: a misaligned jump was rejected. Present only with PC_GEN_ALIGN_CHK_EN; otherwise tied to 0.

## Operation

- FSM states:
  - BOOT, entered on reset: pc_valid_o=0.
  - RUN: pc_valid_o=1.
  - BOOT→RUN on the first edge with rst=1, whether or not a redirect is present. RUN→BOOT only via reset.
- Next-PC selection, first match wins:
  1. reset
  2. trap_en_i
  3. jump_en_i, if accepted
  4. advance
  5. hold
- Trap: pc ← trap_addr_i, epoch toggles, redirect_o=1 next cycle. Applies in BOOT and RUN, regardless of hold_i or pc_ready_i.
- Jump: same as trap with jump_addr_i. Ignored when trap_en_i is high in the same cycle.
- Advance: in RUN with pc_valid_o && pc_ready_i && !hold_i, pc ← pc + STEP, modulo 2^AW. All-ones minus STEP+1 wraps to 0 with no flag.
- Hold or no handshake: pc, epoch and pc_valid_o remain unchanged.
- Handshake rule: while pc_valid_o=1 and the address has not been accepted, pc_o and epoch_o stay stable. The only exception is a redirect, which may replace pc_o before acceptance. The superseded address is dropped and no accept is owed for it.
- Alignment without the macro: the low log2(STEP) bits of every redirect target are forced to 0.
- Reset mid-operation (rst=0 at any edge): pc=RESET_VEC, epoch=0, state=BOOT. All inputs that cycle are ignored.

## Timing

- Reset values: pc_o=RESET_VEC, pc_valid_o=0, epoch_o=0, redirect_o=0, misalign_o=0.
- Reset release: the first edge with rst=1 enters RUN. pc_valid_o=1 with pc_o=RESET_VEC is visible after that edge, a latency of 1 cycle.
- Redirect latency: request at edge N; pc_o=target, toggled epoch_o and redirect_o=1 all visible after edge N+1. redirect_o drops after N+2 unless another redirect occurs.
- Back-to-back redirects each toggle the epoch. Two consecutive redirects return epoch_o to its original value.
- Throughput: one address per cycle while pc_ready_i=1 and hold_i=0.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration

- PC_GEN_ALIGN_CHK_EN defined:
  - A jump target with any of the low log2(STEP) bits set is rejected. pc, epoch and valid behave as if jump_en_i=0, and misalign_o pulses for one cycle after the edge.
  - Traps are never checked; their low bits are forced to 0.
- PC_GEN_ALIGN_CHK_EN undefined: no check is performed, jump low bits are forced to 0, and misalign_o is constant 0.

## Structure

- Shared package pc_gen_pkg holds:
  - the state enum {PCG_BOOT, PCG_RUN};
  - a redirect-cause enum {RD_NONE, RD_TRAP, RD_JUMP};
  - the default STEP constant.
- Sub-module pc_redirect_sel: combinational priority select, low-bit masking and, under the macro, the misalignment detect. Outputs are take, cause, target and misalign.
- The top level holds the FSM, pc/epoch registers and output flops.

## Test plan

- Reset and boot: hold rst=0 for 3 cycles with RESET_VEC=0x8000_0000, then release with pc_ready_i=1. Required: pc_valid_o rises one cycle after release; pc_o sequence 0x8000_0000, 0x8000_0004, 0x8000_0008.
- Backpressure and hold: pc_ready_i=0 for 4 cycles, then hold_i=1 with ready=1 for 2 cycles. Required: pc_o stays constant throughout; it advances by STEP only once both are released.
- Simultaneous redirects: trap_en_i=1 (0x100) and jump_en_i=1 (0x200) in the same cycle. Required: next pc_o=0x100, epoch toggles once, redirect_o pulses for one cycle.
- Wrap-around: AW=32, STEP=4, redirect to 0xFFFF_FFFC, then accept two addresses. Required: pc_o goes 0xFFFF_FFFC then 0x0000_0000.
- Alignment, with PC_GEN_ALIGN_CHK_EN: jump to 0x102 with STEP=4. Required: pc continues sequentially, epoch unchanged, misalign_o=1 for one cycle. Without the macro the same stimulus gives pc_o=0x100.
- Reset mid-redirect: assert rst=0 in the same cycle as jump_en_i=1. Required: pc_o=RESET_VEC, epoch_o=0, pc_valid_o=0, redirect_o=0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_gen_pkg;

  typedef enum logic [0:0] {PCG_BOOT, PCG_RUN} pcg_state_e;

  typedef enum logic [1:0] {RD_NONE, RD_TRAP, RD_JUMP} rd_cause_e;

  localparam int unsigned DefaultStep = 4;

  // Number of address bits below STEP alignment (STEP is 2, 4 or 8).
  function automatic int unsigned step_bits(input int unsigned step);
    case (step)
      2:       return 1;
      8:       return 3;
      default: return 2;
    endcase
  endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Priority redirect select (trap over jump) with low-bit alignment masking.
// Misaligned-jump rejection is built only when PC_GEN_ALIGN_CHK_EN is defined.
module pc_redirect_sel
  import pc_gen_pkg::*;
#(
  parameter int unsigned AW   = 64,
  parameter int unsigned STEP = DefaultStep
) (
  input  logic          trap_en_i,
  input  logic [AW-1:0] trap_addr_i,
  input  logic          jump_en_i,
  input  logic [AW-1:0] jump_addr_i,
  output logic          take_o,
  output rd_cause_e     cause_o,
  output logic [AW-1:0] target_o,
  output logic          misalign_o
);

  localparam int unsigned LowBits = step_bits(STEP);
  localparam logic [AW-1:0] AlignMask = {AW{1'b1}} << LowBits;

`ifdef PC_GEN_ALIGN_CHK_EN
  logic jump_misaligned;
  assign jump_misaligned = |(jump_addr_i & ~AlignMask);
`endif

  always_comb begin
    take_o     = 1'b0;
    cause_o    = RD_NONE;
    target_o   = trap_addr_i & AlignMask;
    misalign_o = 1'b0;
    if (trap_en_i) begin
      take_o   = 1'b1;
      cause_o  = RD_TRAP;
      target_o = trap_addr_i & AlignMask;
    end else if (jump_en_i) begin
`ifdef PC_GEN_ALIGN_CHK_EN
      if (jump_misaligned) begin
        misalign_o = 1'b1;
      end else begin
        take_o   = 1'b1;
        cause_o  = RD_JUMP;
        target_o = jump_addr_i & AlignMask;
      end
`else
      take_o   = 1'b1;
      cause_o  = RD_JUMP;
      target_o = jump_addr_i & AlignMask;
`endif
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN FSM, pc/epoch registers, registered outputs.
// Optional misaligned-jump rejection via PC_GEN_ALIGN_CHK_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned   AW        = 64,
  parameter logic [AW-1:0] RESET_VEC = '0,
  parameter int unsigned   STEP      = DefaultStep
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trap_en_i,
  input  logic [AW-1:0] trap_addr_i,
  input  logic          jump_en_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          hold_i,
  output logic [AW-1:0] pc_o,
  output logic          pc_valid_o,
  input  logic          pc_ready_i,
  output logic          epoch_o,
  output logic          redirect_o,
  output logic          misalign_o
);

  pcg_state_e    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          epoch_q, epoch_d;
  logic          redirect_q, redirect_d;
  logic          misalign_q, misalign_d;

  logic          take;
  rd_cause_e     cause;
  logic [AW-1:0] target;
  logic          misalign;

  pc_redirect_sel #(
    .AW   (AW),
    .STEP (STEP)
  ) u_redirect_sel (
    .trap_en_i   (trap_en_i),
    .trap_addr_i (trap_addr_i),
    .jump_en_i   (jump_en_i),
    .jump_addr_i (jump_addr_i),
    .take_o      (take),
    .cause_o     (cause),
    .target_o    (target),
    .misalign_o  (misalign)
  );

  always_comb begin
    state_d    = PCG_RUN;
    pc_d       = pc_q;
    epoch_d    = epoch_q;
    redirect_d = (cause != RD_NONE);
    misalign_d = misalign;
    if (take) begin
      pc_d    = target;
      epoch_d = ~epoch_q;
    end else if (state_q == PCG_RUN && pc_ready_i && !hold_i) begin
      pc_d = pc_q + AW'(STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= PCG_BOOT;
      pc_q       <= RESET_VEC;
      epoch_q    <= 1'b0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = (state_q == PCG_RUN);
  assign epoch_o    = epoch_q;
  assign redirect_o = redirect_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (AW=32, RESET_VEC=0x8000_0000, STEP=4).
// Honours PC_GEN_ALIGN_CHK_EN for the alignment scenario.
module tb_pc_gen;

  localparam int unsigned   AW  = 32;
  localparam logic [31:0]   RV  = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          trap_en_i;
  logic [AW-1:0] trap_addr_i;
  logic          jump_en_i;
  logic [AW-1:0] jump_addr_i;
  logic          hold_i;
  logic [AW-1:0] pc_o;
  logic          pc_valid_o;
  logic          pc_ready_i;
  logic          epoch_o;
  logic          redirect_o;
  logic          misalign_o;

  int total = 0;
  int bad   = 0;
  logic exp_epoch = 1'b0;

  always #5 clk = ~clk;

  pc_gen #(
    .AW        (AW),
    .RESET_VEC (RV),
    .STEP      (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trap_en_i   (trap_en_i),
    .trap_addr_i (trap_addr_i),
    .jump_en_i   (jump_en_i),
    .jump_addr_i (jump_addr_i),
    .hold_i      (hold_i),
    .pc_o        (pc_o),
    .pc_valid_o  (pc_valid_o),
    .pc_ready_i  (pc_ready_i),
    .epoch_o     (epoch_o),
    .redirect_o  (redirect_o),
    .misalign_o  (misalign_o)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; trap_en_i = 1'b0; jump_en_i = 1'b0; hold_i = 1'b0; pc_ready_i = 1'b1;
    trap_addr_i = '0; jump_addr_i = '0;
    repeat (3) tick();
    total++; if (pc_o !== RV) begin bad++; $display("FAIL reset_pc: got %h want %h", pc_o, RV); end
    total++; if (pc_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", pc_valid_o); end
    total++; if (epoch_o !== 1'b0) begin bad++; $display("FAIL reset_epoch: got %b want 0", epoch_o); end
    total++; if (redirect_o !== 1'b0) begin bad++; $display("FAIL reset_redirect: got %b want 0", redirect_o); end
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL reset_misalign: got %b want 0", misalign_o); end
    rst = 1'b1;
    tick();
    total++; if (pc_valid_o !== 1'b1) begin bad++; $display("FAIL boot_valid: got %b want 1", pc_valid_o); end
    total++; if (pc_o !== 32'h8000_0000) begin bad++; $display("FAIL boot_pc0: got %h want 80000000", pc_o); end
    tick();
    total++; if (pc_o !== 32'h8000_0004) begin bad++; $display("FAIL boot_pc1: got %h want 80000004", pc_o); end
    tick();
    total++; if (pc_o !== 32'h8000_0008) begin bad++; $display("FAIL boot_pc2: got %h want 80000008", pc_o); end
    exp_epoch = 1'b0;
  endtask

  task automatic test_backpressure();
    pc_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (pc_o !== 32'h8000_0008) begin bad++; $display("FAIL stall_ready%0d: got %h want 80000008", i, pc_o); end
    end
    pc_ready_i = 1'b1; hold_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (pc_o !== 32'h8000_0008) begin bad++; $display("FAIL stall_hold%0d: got %h want 80000008", i, pc_o); end
    end
    // Hold must not block a redirect.
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0600;
    tick();
    jump_en_i = 1'b0;
    exp_epoch = ~exp_epoch;
    total++; if (pc_o !== 32'h0000_0600) begin bad++; $display("FAIL hold_jump_pc: got %h want 00000600", pc_o); end
    total++; if (epoch_o !== exp_epoch) begin bad++; $display("FAIL hold_jump_epoch: got %b want %b", epoch_o, exp_epoch); end
    hold_i = 1'b0;
    tick();
    pc_ready_i = 1'b0;
    total++; if (pc_o !== 32'h0000_0604) begin bad++; $display("FAIL release_pc: got %h want 00000604", pc_o); end
    total++; if (redirect_o !== 1'b0) begin bad++; $display("FAIL release_redirect: got %b want 0", redirect_o); end
  endtask

  task automatic test_simul_redirect();
    trap_en_i = 1'b1; trap_addr_i = 32'h0000_0100;
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0200;
    tick();
    trap_en_i = 1'b0; jump_en_i = 1'b0;
    exp_epoch = ~exp_epoch;
    total++; if (pc_o !== 32'h0000_0100) begin bad++; $display("FAIL simul_pc: got %h want 00000100", pc_o); end
    total++; if (epoch_o !== exp_epoch) begin bad++; $display("FAIL simul_epoch: got %b want %b", epoch_o, exp_epoch); end
    total++; if (redirect_o !== 1'b1) begin bad++; $display("FAIL simul_redirect: got %b want 1", redirect_o); end
    tick();
    total++; if (redirect_o !== 1'b0) begin bad++; $display("FAIL simul_redirect_drop: got %b want 0", redirect_o); end
    total++; if (pc_o !== 32'h0000_0100) begin bad++; $display("FAIL simul_pc_hold: got %h want 00000100", pc_o); end
    // Trap low bits are always forced to zero.
    trap_en_i = 1'b1; trap_addr_i = 32'h0000_0203;
    tick();
    trap_en_i = 1'b0;
    exp_epoch = ~exp_epoch;
    total++; if (pc_o !== 32'h0000_0200) begin bad++; $display("FAIL trap_mask_pc: got %h want 00000200", pc_o); end
    total++; if (epoch_o !== exp_epoch) begin bad++; $display("FAIL trap_mask_epoch: got %b want %b", epoch_o, exp_epoch); end
  endtask

  task automatic test_back_to_back();
    logic start_epoch;
    start_epoch = exp_epoch;
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0300;
    tick();
    exp_epoch = ~exp_epoch;
    total++; if (pc_o !== 32'h0000_0300) begin bad++; $display("FAIL b2b_pc0: got %h want 00000300", pc_o); end
    total++; if (epoch_o !== exp_epoch) begin bad++; $display("FAIL b2b_epoch0: got %b want %b", epoch_o, exp_epoch); end
    jump_addr_i = 32'h0000_0400;
    tick();
    jump_en_i = 1'b0;
    exp_epoch = ~exp_epoch;
    total++; if (pc_o !== 32'h0000_0400) begin bad++; $display("FAIL b2b_pc1: got %h want 00000400", pc_o); end
    total++; if (epoch_o !== start_epoch) begin bad++; $display("FAIL b2b_epoch1: got %b want %b", epoch_o, start_epoch); end
    total++; if (redirect_o !== 1'b1) begin bad++; $display("FAIL b2b_redirect: got %b want 1", redirect_o); end
    tick();
    total++; if (redirect_o !== 1'b0) begin bad++; $display("FAIL b2b_redirect_drop: got %b want 0", redirect_o); end
  endtask

  task automatic test_wrap();
    jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
    tick();
    jump_en_i = 1'b0;
    exp_epoch = ~exp_epoch;
    total++; if (pc_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc0: got %h want fffffffc", pc_o); end
    pc_ready_i = 1'b1;
    tick();
    total++; if (pc_o !== 32'h0000_0000) begin bad++; $display("FAIL wrap_pc1: got %h want 00000000", pc_o); end
    tick();
    pc_ready_i = 1'b0;
    total++; if (pc_o !== 32'h0000_0004) begin bad++; $display("FAIL wrap_pc2: got %h want 00000004", pc_o); end
    total++; if (epoch_o !== exp_epoch) begin bad++; $display("FAIL wrap_epoch: got %b want %b", epoch_o, exp_epoch); end
  endtask

  task automatic test_align();
    pc_ready_i = 1'b0;
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0102;
    tick();
    jump_en_i = 1'b0;
`ifdef PC_GEN_ALIGN_CHK_EN
    total++; if (pc_o !== 32'h0000_0004) begin bad++; $display("FAIL align_pc: got %h want 00000004", pc_o); end
    total++; if (epoch_o !== exp_epoch) begin bad++; $display("FAIL align_epoch: got %b want %b", epoch_o, exp_epoch); end
    total++; if (misalign_o !== 1'b1) begin bad++; $display("FAIL align_misalign: got %b want 1", misalign_o); end
    total++; if (redirect_o !== 1'b0) begin bad++; $display("FAIL align_redirect: got %b want 0", redirect_o); end
`else
    exp_epoch = ~exp_epoch;
    total++; if (pc_o !== 32'h0000_0100) begin bad++; $display("FAIL align_pc: got %h want 00000100", pc_o); end
    total++; if (epoch_o !== exp_epoch) begin bad++; $display("FAIL align_epoch: got %b want %b", epoch_o, exp_epoch); end
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL align_misalign: got %b want 0", misalign_o); end
    total++; if (redirect_o !== 1'b1) begin bad++; $display("FAIL align_redirect: got %b want 1", redirect_o); end
`endif
    tick();
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL align_misalign_drop: got %b want 0", misalign_o); end
  endtask

  task automatic test_reset_mid_redirect();
    pc_ready_i = 1'b1;
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0500;
    rst = 1'b0;
    tick();
    jump_en_i = 1'b0;
    total++; if (pc_o !== RV) begin bad++; $display("FAIL midrst_pc: got %h want %h", pc_o, RV); end
    total++; if (epoch_o !== 1'b0) begin bad++; $display("FAIL midrst_epoch: got %b want 0", epoch_o); end
    total++; if (pc_valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", pc_valid_o); end
    total++; if (redirect_o !== 1'b0) begin bad++; $display("FAIL midrst_redirect: got %b want 0", redirect_o); end
    rst = 1'b1;
    tick();
    total++; if (pc_valid_o !== 1'b1 || pc_o !== RV) begin
      bad++; $display("FAIL midrst_reboot: got valid=%b pc=%h want valid=1 pc=%h", pc_valid_o, pc_o, RV);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_backpressure();
    test_simul_redirect();
    test_back_to_back();
    test_wrap();
    test_align();
    test_reset_mid_redirect();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
